// File: rtl/line_code_pkg.sv
// Shared definitions for the line-code encoder and its future decoder:
// mode codes, FSM state encodings and the per-half-bit encode function.
package line_code_pkg;

    localparam logic [1:0] MODE_NRZ        = 2'b00;
    localparam logic [1:0] MODE_NRZI       = 2'b01;
    localparam logic [1:0] MODE_MAN_IEEE   = 2'b10;
    localparam logic [1:0] MODE_MAN_THOMAS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_SECOND = 2'd2
    } state_t;

    // Line level for one half of bit b; NRZI uses the already-updated level.
    function automatic logic encode_bit(
        input logic [1:0] mode,
        input logic       b,
        input logic       second_half,
        input logic       nrzi_level
    );
        logic lvl;
        case (mode)
            MODE_NRZ:      lvl = b;
            MODE_NRZI:     lvl = nrzi_level;
            MODE_MAN_IEEE: lvl = second_half ? b : ~b;
            default:       lvl = second_half ? ~b : b;
        endcase
        return lvl;
    endfunction

endpackage

// File: rtl/half_bit_timer.sv
// Half-bit period counter: ticks on the last clk of every half-bit while running.
module half_bit_timer #(
    parameter int unsigned HALF_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int unsigned HALF_W = $clog2(HALF_CYCLES) + 1;

    logic [HALF_W-1:0] cnt;

    assign tick = run && (cnt == HALF_W'(HALF_CYCLES - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= tick ? '0 : cnt + HALF_W'(1);
        end
    end

endmodule

// File: rtl/line_code_encoder.sv
// Serial line-code encoder: MSB-first serialisation of WIDTH-bit words in
// NRZ, NRZI or either Manchester convention, with gapless back-to-back words.
module line_code_encoder
    import line_code_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned HALF_CYCLES = 1,
    parameter logic        IDLE_LEVEL  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic             flush,
    output logic             out,
    output logic             word_done,
    output logic [1:0]       state,
    output logic [1:0]       nstate
);

    localparam int unsigned BIT_W = $clog2(WIDTH) + 1;

    state_t             cur_state;
    state_t             next_state;
    logic [WIDTH-1:0]   shreg;
    logic [WIDTH-1:0]   shreg_n;
    logic [1:0]         mode_q;
    logic [1:0]         mode_n;
    logic [BIT_W-1:0]   bit_cnt;
    logic [BIT_W-1:0]   bit_cnt_n;
    logic               nrzi_level;
    logic               nrzi_level_n;
    logic               out_n;
    logic               cur_bit;
    logic               bit_start;
    logic               tick;
    logic               last_bit;
    logic               word_end;
    logic               accept;

    half_bit_timer #(
        .HALF_CYCLES(HALF_CYCLES)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(accept || flush),
        .run  (cur_state != ST_IDLE),
        .tick (tick)
    );

    assign last_bit  = (bit_cnt == BIT_W'(WIDTH - 1));
    assign word_end  = (cur_state == ST_SECOND) && tick && last_bit;
    assign in_ready  = (cur_state == ST_IDLE) || word_end;
    assign accept    = in_valid && in_ready && !flush;
    assign word_done = word_end;
    assign state     = cur_state;
    assign nstate    = next_state;

    always_comb begin
        next_state = cur_state;
        if (flush) begin
            next_state = ST_IDLE;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    if (accept) next_state = ST_FIRST;
                end
                ST_FIRST: begin
                    if (tick) next_state = ST_SECOND;
                end
                ST_SECOND: begin
                    if (tick) begin
                        if (!last_bit || accept) next_state = ST_FIRST;
                        else                     next_state = ST_IDLE;
                    end
                end
                default: next_state = ST_IDLE;
            endcase
        end
    end

    // Next-cycle datapath; out is registered from the level of the next state.
    always_comb begin
        shreg_n      = shreg;
        mode_n       = mode_q;
        bit_cnt_n    = bit_cnt;
        nrzi_level_n = nrzi_level;
        if (flush) begin
            bit_cnt_n = '0;
        end else if (accept) begin
            shreg_n   = in_data;
            mode_n    = mode;
            bit_cnt_n = '0;
        end else if ((cur_state == ST_SECOND) && tick && !last_bit) begin
            shreg_n   = shreg << 1;
            bit_cnt_n = bit_cnt + BIT_W'(1);
        end

        cur_bit   = shreg_n[WIDTH-1];
        bit_start = (next_state == ST_FIRST) && (cur_state != ST_FIRST);
        if (bit_start && (mode_n == MODE_NRZI)) begin
            nrzi_level_n = nrzi_level ^ cur_bit;
        end

        if (next_state == ST_IDLE) begin
            out_n = (mode_n == MODE_NRZI) ? nrzi_level_n : IDLE_LEVEL;
        end else begin
            out_n = encode_bit(mode_n, cur_bit, next_state == ST_SECOND, nrzi_level_n);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state  <= ST_IDLE;
            shreg      <= '0;
            mode_q     <= MODE_NRZ;
            bit_cnt    <= '0;
            nrzi_level <= IDLE_LEVEL;
            out        <= IDLE_LEVEL;
        end else begin
            cur_state  <= next_state;
            shreg      <= shreg_n;
            mode_q     <= mode_n;
            bit_cnt    <= bit_cnt_n;
            nrzi_level <= nrzi_level_n;
            out        <= out_n;
        end
    end

endmodule

// File: tb/tb_line_code_encoder.sv
// Scoreboard bench for line_code_encoder: expected line levels are queued when
// a word is presented and popped one per clk as the encoder drives the line.
module tb_line_code_encoder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;

    logic [3:0] a_data = '0;
    logic       a_valid = 1'b0;
    logic       a_ready;
    logic [1:0] a_mode = 2'b00;
    logic       a_flush = 1'b0;
    logic       a_out;
    logic       a_done;
    logic [1:0] a_state;
    logic [1:0] a_nstate;

    logic [3:0] b_data = '0;
    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [1:0] b_mode = 2'b00;
    logic       b_flush = 1'b0;
    logic       b_out;
    logic       b_done;
    logic [1:0] b_state;
    logic [1:0] b_nstate;

    int checks = 0;
    int errors = 0;
    logic exp_q[$];
    logic model_nrzi = 1'b0;

    always #5 clk = ~clk;

    line_code_encoder #(.WIDTH(4), .HALF_CYCLES(1), .IDLE_LEVEL(1'b0)) dut_a (
        .clk(clk), .reset(reset), .in_data(a_data), .in_valid(a_valid),
        .in_ready(a_ready), .mode(a_mode), .flush(a_flush), .out(a_out),
        .word_done(a_done), .state(a_state), .nstate(a_nstate)
    );

    line_code_encoder #(.WIDTH(4), .HALF_CYCLES(3), .IDLE_LEVEL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .mode(b_mode), .flush(b_flush), .out(b_out),
        .word_done(b_done), .state(b_state), .nstate(b_nstate)
    );

    // Expected line levels for one word, MSB first, hc clks per half-bit.
    task automatic push_word(input logic [3:0] w, input logic [1:0] m, input int hc);
        logic b, h1, h2;
        for (int i = 3; i >= 0; i--) begin
            b = w[i];
            case (m)
                2'b00: begin h1 = b; h2 = b; end
                2'b01: begin
                    if (b) model_nrzi = ~model_nrzi;
                    h1 = model_nrzi; h2 = model_nrzi;
                end
                2'b10: begin h1 = ~b; h2 = b; end
                default: begin h1 = b; h2 = ~b; end
            endcase
            repeat (hc) exp_q.push_back(h1);
            repeat (hc) exp_q.push_back(h2);
        end
    endtask

    function automatic logic pop_exp();
        if (exp_q.size() == 0) return 1'bx;
        return exp_q.pop_front();
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (a_out !== 1'b0)    begin errors++; $display("FAIL reset_out got %b want 0", a_out); end
        checks++; if (a_ready !== 1'b1)  begin errors++; $display("FAIL reset_ready got %b want 1", a_ready); end
        checks++; if (a_done !== 1'b0)   begin errors++; $display("FAIL reset_done got %b want 0", a_done); end
        checks++; if (a_state !== 2'd0)  begin errors++; $display("FAIL reset_state got %0d want 0", a_state); end
        checks++; if (b_out !== 1'b0)    begin errors++; $display("FAIL reset_b_out got %b want 0", b_out); end
        checks++; if (b_ready !== 1'b1)  begin errors++; $display("FAIL reset_b_ready got %b want 1", b_ready); end
        reset = 1'b0;
        model_nrzi = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    // One isolated word on the fast encoder, checking every line clk.
    task automatic test_word(input string name, input logic [3:0] w, input logic [1:0] m);
        logic e;
        logic idle_exp;
        @(negedge clk);
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL %s_ready_idle got %b want 1", name, a_ready); end
        a_data = w; a_mode = m; a_valid = 1'b1;
        push_word(w, m, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) a_valid = 1'b0;
            e = pop_exp();
            checks++; if (a_out !== e) begin errors++; $display("FAIL %s_out clk %0d got %b want %b", name, k + 1, a_out, e); end
            if (k == 0) begin
                checks++; if (a_nstate !== 2'd2) begin errors++; $display("FAIL %s_nstate clk1 got %0d want 2", name, a_nstate); end
            end
            if (k == 7) begin
                checks++; if (a_done !== 1'b1)   begin errors++; $display("FAIL %s_done got %b want 1", name, a_done); end
                checks++; if (a_ready !== 1'b1)  begin errors++; $display("FAIL %s_ready_end got %b want 1", name, a_ready); end
                checks++; if (a_nstate !== 2'd0) begin errors++; $display("FAIL %s_nstate_end got %0d want 0", name, a_nstate); end
            end else begin
                checks++; if (a_done !== 1'b0)   begin errors++; $display("FAIL %s_done_early clk %0d got %b want 0", name, k + 1, a_done); end
            end
        end
        idle_exp = (m == 2'b01) ? model_nrzi : 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++; if (a_state !== 2'd0)    begin errors++; $display("FAIL %s_idle_state got %0d want 0", name, a_state); end
            checks++; if (a_out !== idle_exp)  begin errors++; $display("FAIL %s_idle_out got %b want %b", name, a_out, idle_exp); end
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        int done_cnt;
        done_cnt = 0;
        @(negedge clk);
        a_data = 4'b1010; a_mode = 2'b10; a_valid = 1'b1;
        push_word(4'b1010, 2'b10, 1);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (k == 0) begin a_data = 4'b0011; a_mode = 2'b00; end
            if (k == 8) a_valid = 1'b0;
            e = pop_exp();
            checks++; if (a_out !== e)       begin errors++; $display("FAIL b2b_out clk %0d got %b want %b", k + 1, a_out, e); end
            checks++; if (a_state === 2'd0)  begin errors++; $display("FAIL b2b_gap clk %0d got state 0 want busy", k + 1); end
            if (a_done === 1'b1) done_cnt++;
            if (k == 7 || k == 15) begin
                checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL b2b_done clk %0d got %b want 1", k + 1, a_done); end
            end
            if (k == 7) begin
                checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready clk 8 got %b want 1", a_ready); end
                push_word(4'b0011, 2'b00, 1);
            end
            if (k == 3) begin
                checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_busy got %b want 0", a_ready); end
            end
        end
        checks++; if (done_cnt !== 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", done_cnt); end
        @(negedge clk);
        checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL b2b_idle got %0d want 0", a_state); end
    endtask

    task automatic test_flush();
        logic e;
        @(negedge clk);
        a_data = 4'b1010; a_mode = 2'b10; a_valid = 1'b1;
        push_word(4'b1010, 2'b10, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) a_valid = 1'b0;
            e = pop_exp();
            checks++; if (a_out !== e) begin errors++; $display("FAIL flush_pre_out clk %0d got %b want %b", k + 1, a_out, e); end
        end
        a_flush = 1'b1; a_data = 4'b1111; a_valid = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL flush_state got %0d want 0", a_state); end
        checks++; if (a_out !== 1'b0)   begin errors++; $display("FAIL flush_out got %b want 0", a_out); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got %b want 1", a_ready); end
        checks++; if (a_done !== 1'b0)  begin errors++; $display("FAIL flush_done got %b want 0", a_done); end
        @(negedge clk);
        checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL flush_priority got state %0d want 0", a_state); end
        a_flush = 1'b0; a_valid = 1'b0;
        @(negedge clk);
        checks++; if (a_out !== 1'b0)   begin errors++; $display("FAIL flush_after_out got %b want 0", a_out); end
    endtask

    task automatic test_reset_mid_word();
        logic e;
        @(negedge clk);
        a_data = 4'b1010; a_mode = 2'b10; a_valid = 1'b1;
        push_word(4'b1010, 2'b10, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) a_valid = 1'b0;
            e = pop_exp();
            checks++; if (a_out !== e) begin errors++; $display("FAIL rstmid_pre_out clk %0d got %b want %b", k + 1, a_out, e); end
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (a_out !== 1'b0)   begin errors++; $display("FAIL rstmid_out got %b want 0", a_out); end
        checks++; if (a_state !== 2'd0) begin errors++; $display("FAIL rstmid_state got %0d want 0", a_state); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b want 1", a_ready); end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        model_nrzi = 1'b0;
        @(negedge clk);
    endtask

    // Slow bit rate: second word waits while the first is still on the line.
    task automatic test_slow_rate();
        logic e;
        exp_q.delete();
        @(negedge clk);
        b_data = 4'b0110; b_mode = 2'b00; b_valid = 1'b1;
        push_word(4'b0110, 2'b00, 3);
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            if (k == 0) b_valid = 1'b0;
            if (k == 4) begin b_data = 4'b1000; b_valid = 1'b1; end
            if (k == 24) b_valid = 1'b0;
            e = pop_exp();
            checks++; if (b_out !== e) begin errors++; $display("FAIL slow_out clk %0d got %b want %b", k + 1, b_out, e); end
            if (k >= 4 && k < 23) begin
                checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL slow_wait clk %0d got ready %b want 0", k + 1, b_ready); end
            end
            if (k == 23) begin
                checks++; if (b_ready !== 1'b1)  begin errors++; $display("FAIL slow_ready clk 24 got %b want 1", b_ready); end
                checks++; if (b_done !== 1'b1)   begin errors++; $display("FAIL slow_done clk 24 got %b want 1", b_done); end
                checks++; if (b_nstate !== 2'd1) begin errors++; $display("FAIL slow_nstate clk 24 got %0d want 1", b_nstate); end
                push_word(4'b1000, 2'b00, 3);
            end
            if (k == 24) begin
                checks++; if (b_state !== 2'd1) begin errors++; $display("FAIL slow_start clk 25 got state %0d want 1", b_state); end
            end
            if (k == 47) begin
                checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL slow_done2 got %b want 1", b_done); end
            end
        end
        @(negedge clk);
        checks++; if (b_state !== 2'd0) begin errors++; $display("FAIL slow_idle got %0d want 0", b_state); end
    endtask

    initial begin
        test_reset();
        test_word("man_ieee", 4'b1010, 2'b10);
        test_word("man_thomas", 4'b1010, 2'b11);
        test_word("nrzi", 4'b1101, 2'b01);
        test_back_to_back();
        test_flush();
        test_reset_mid_word();
        test_slow_rate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
